memory_r2_up_1_port: RTL and testbench

Word-access port for long tank 1 of the upper r2 store. Holds the minor-cycle timebase, accepts one short-word read or write request at a time, and waits for the addressed word to circulate past. It then drives the tank's clear/in/out gates and the serial input bus, and deserialises the tank's output bus into a parallel response. It sits directly upstream of the tank delay line (drives `r2_up_t1_clr/in/out`, `r2_mib`) and directly downstream of it (consumes `r2_up_mob_t1`).

---
 rtl/memory_pkg.sv | 20 ++
 rtl/memory_r2_timebase.sv | 55 +++++
 rtl/memory_r2_up_1_port.sv | 146 ++++++++++++++
 tb/tb_memory_r2_up_1_port.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// Shared constants and state encoding for the r2 store tank word-access ports.
// Contents: WORD_BITS, DIGITS, MINOR_CYCLES geometry, counter widths,
//           and the port FSM state enum (IDLE, WAIT, XFER, DONE).
package memory_pkg;

  localparam int WORD_BITS    = 17;  // data bits per short word
  localparam int DIGITS       = 18;  // pulse positions per minor cycle (17 data + gap)
  localparam int MINOR_CYCLES = 32;  // short words per long tank

  localparam int DIGIT_W = 5;
  localparam int MINOR_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } port_state_e;

endpackage

// File: rtl/memory_r2_timebase.sv
// Free-running minor-cycle timebase for the r2 store: digit 0..DIGITS-1 and
// minor 0..MINOR_CYCLES-1, plus the next-cycle counter value for registered
// lookahead and a major_sync pulse in the last digit of the last minor cycle.
// Ports: clk_i/rst_i (async active-high), digit_o/minor_o, digit_nxt_o/minor_nxt_o, major_sync_o.
module memory_r2_timebase #(
  parameter int DIGITS       = memory_pkg::DIGITS,
  parameter int MINOR_CYCLES = memory_pkg::MINOR_CYCLES
) (
  input  logic       clk_i,
  input  logic       rst_i,
  output logic [4:0] digit_o,
  output logic [4:0] minor_o,
  output logic [4:0] digit_nxt_o,
  output logic [4:0] minor_nxt_o,
  output logic       major_sync_o
);
  import memory_pkg::*;

  localparam logic [DIGIT_W-1:0] DIGIT_LAST = DIGIT_W'(DIGITS - 1);
  localparam logic [MINOR_W-1:0] MINOR_LAST = MINOR_W'(MINOR_CYCLES - 1);

  logic [DIGIT_W-1:0] digit_q, digit_d;
  logic [MINOR_W-1:0] minor_q, minor_d;
  logic               major_sync_q, major_sync_d;

  always_comb begin
    digit_d = digit_q + DIGIT_W'(1);
    minor_d = minor_q;
    if (digit_q == DIGIT_LAST) begin
      digit_d = '0;
      minor_d = (minor_q == MINOR_LAST) ? '0 : minor_q + MINOR_W'(1);
    end
    // Registered so it is high in the cycle whose counter reads (last, last).
    major_sync_d = (digit_d == DIGIT_LAST) && (minor_d == MINOR_LAST);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      digit_q      <= '0;
      minor_q      <= '0;
      major_sync_q <= 1'b0;
    end else begin
      digit_q      <= digit_d;
      minor_q      <= minor_d;
      major_sync_q <= major_sync_d;
    end
  end

  assign digit_o      = digit_q;
  assign minor_o      = minor_q;
  assign digit_nxt_o  = digit_d;
  assign minor_nxt_o  = minor_d;
  assign major_sync_o = major_sync_q;

endmodule

// File: rtl/memory_r2_up_1_port.sv
// Word-access port for long tank 1 of the upper r2 store: accepts one read or
// write at a time, waits for the addressed slot to circulate past, drives the
// tank clr/in/out gates and serial input, and deserialises the tank output.
// Ports: r2_clk/r2_rst, req_* (valid/ready request), rsp_* (one-cycle response),
//        r2_up_t1_clr/in/out + r2_mib (tank drive), r2_up_mob_t1 (tank output),
//        minor/digit/major_sync (timebase).
module memory_r2_up_1_port #(
  parameter int WORD_BITS    = memory_pkg::WORD_BITS,
  parameter int DIGITS       = memory_pkg::DIGITS,
  parameter int MINOR_CYCLES = memory_pkg::MINOR_CYCLES
) (
  input  logic                 r2_clk,
  input  logic                 r2_rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [4:0]           req_addr,
  input  logic [WORD_BITS-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [WORD_BITS-1:0] rsp_rdata,
  output logic                 r2_up_t1_clr,
  output logic                 r2_up_t1_in,
  output logic                 r2_up_t1_out,
  output logic                 r2_mib,
  input  logic                 r2_up_mob_t1,
  output logic [4:0]           minor,
  output logic [4:0]           digit,
  output logic                 major_sync
);
  import memory_pkg::*;

  localparam logic [4:0] GAP = 5'(DIGITS - 1);

  logic [4:0] digit_q, minor_q, digit_nxt, minor_nxt;

  memory_r2_timebase #(
    .DIGITS       (DIGITS),
    .MINOR_CYCLES (MINOR_CYCLES)
  ) u_timebase (
    .clk_i        (r2_clk),
    .rst_i        (r2_rst),
    .digit_o      (digit_q),
    .minor_o      (minor_q),
    .digit_nxt_o  (digit_nxt),
    .minor_nxt_o  (minor_nxt),
    .major_sync_o (major_sync)
  );

  port_state_e          state_q, state_d;
  logic [4:0]           addr_q;
  logic                 write_q;
  logic [WORD_BITS-1:0] wdata_q;
  logic [WORD_BITS-1:0] cap_q;
  logic [WORD_BITS-1:0] rdata_q;
  logic                 rsp_valid_q;
  logic                 ready_q;
  logic                 clr_q, in_q, out_q, mib_q;
  logic                 clr_d, in_d, out_d, mib_d;

  logic                 accept;
  logic [4:0]           tgt_addr;
  logic                 tgt_write;
  logic [WORD_BITS-1:0] tgt_wdata;
  logic                 slot_start_nxt;
  logic                 drive_nxt;

  assign accept = req_valid && ready_q;

  // In the accept cycle the request fields are not latched yet, so the
  // lookahead uses them directly; afterwards it uses the latched copy.
  assign tgt_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
  assign tgt_write = (state_q == ST_IDLE) ? req_write : write_q;
  assign tgt_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;

  // Next cycle is digit 0 of the target slot: the transfer must already be
  // live in that cycle, so the decision is made one cycle early.
  assign slot_start_nxt = (minor_nxt == tgt_addr) && (digit_nxt == '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = slot_start_nxt ? ST_XFER : ST_WAIT;
      ST_WAIT: if (slot_start_nxt) state_d = ST_XFER;
      ST_XFER: if (digit_q == GAP) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Gates for the next cycle: only data digits of the slot, never the gap.
  always_comb begin
    drive_nxt = (state_d == ST_XFER) && (digit_nxt != GAP);
    clr_d     = drive_nxt && tgt_write;
    in_d      = drive_nxt && tgt_write;
    out_d     = drive_nxt && !tgt_write;
    mib_d     = drive_nxt && tgt_write && tgt_wdata[digit_nxt];
  end

  always_ff @(posedge r2_clk or posedge r2_rst) begin
    if (r2_rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      cap_q       <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      ready_q     <= 1'b1;
      clr_q       <= 1'b0;
      in_q        <= 1'b0;
      out_q       <= 1'b0;
      mib_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= (state_d == ST_IDLE);
      rsp_valid_q <= (state_d == ST_DONE);
      clr_q       <= clr_d;
      in_q        <= in_d;
      out_q       <= out_d;
      mib_q       <= mib_d;
      if (accept) begin
        addr_q  <= req_addr;
        write_q <= req_write;
        wdata_q <= req_wdata;
      end
      // out_q is only high on data digits, so digit_q is always a valid bit index here.
      if (state_q == ST_XFER && out_q) begin
        cap_q[digit_q] <= r2_up_mob_t1;
      end
      if (state_q == ST_XFER && state_d == ST_DONE) begin
        rdata_q <= write_q ? wdata_q : cap_q;
      end
    end
  end

  assign req_ready    = ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rdata_q;
  assign r2_up_t1_clr = clr_q;
  assign r2_up_t1_in  = in_q;
  assign r2_up_t1_out = out_q;
  assign r2_mib       = mib_q;
  assign minor        = minor_q;
  assign digit        = digit_q;

endmodule

// File: tb/tb_memory_r2_up_1_port.sv
// Bench for memory_r2_up_1_port: circulating tank model, word-level memory
// reference, and latency computed from slot position.
module tb_memory_r2_up_1_port;

  localparam int NW = 17;
  localparam int ND = 18;
  localparam int NM = 32;
  localparam int NP = ND * NM;

  logic          r2_clk = 1'b0;
  logic          r2_rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [4:0]    req_addr = '0;
  logic [NW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic [NW-1:0] rsp_rdata;
  logic          clr, tin, tout, mib;
  logic          mob = 1'b0;
  logic [4:0]    minor, digit;
  logic          major_sync;

  always #5 r2_clk = ~r2_clk;

  memory_r2_up_1_port dut (
    .r2_clk       (r2_clk),
    .r2_rst       (r2_rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .r2_up_t1_clr (clr),
    .r2_up_t1_in  (tin),
    .r2_up_t1_out (tout),
    .r2_mib       (mib),
    .r2_up_mob_t1 (mob),
    .minor        (minor),
    .digit        (digit),
    .major_sync   (major_sync)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Absolute pulse position within the major cycle.
  int pos = 0;
  always @(posedge r2_clk or posedge r2_rst) begin
    if (r2_rst) pos <= 0;
    else        pos <= (pos + 1) % NP;
  end

  // Tank: one bit per pulse position, presented/overwritten mid-cycle.
  logic tank [NP];
  int gate_cnt = 0, gate_first = -1, gate_last = -1, gate_bad = 0;
  always @(negedge r2_clk) begin
    mob = tout ? tank[pos] : 1'b0;
    if (clr)      tank[pos] = tin & mib;
    else if (tin) tank[pos] = tank[pos] | mib;
    if (clr || tin || tout) begin
      gate_cnt++;
      if (gate_cnt == 1) gate_first = pos;
      gate_last = pos;
      if (pos % ND == ND - 1) gate_bad++;
    end
  end

  // major_sync must sit on the last pulse of the major cycle, 576 apart.
  int cyc_n = 0, ms_last = -1, ms_pulses = 0, ms_bad = 0;
  always @(negedge r2_clk) begin
    cyc_n++;
    if (r2_rst) ms_last = -1;
    else begin
      if (major_sync !== (pos == NP - 1)) ms_bad++;
      if (major_sync) begin
        if (ms_last >= 0 && cyc_n - ms_last != NP) ms_bad++;
        ms_last = cyc_n;
        ms_pulses++;
      end
    end
  end

  logic [NW-1:0] mem [NM];

  function automatic logic [NW-1:0] tank_word(input int a);
    logic [NW-1:0] w;
    for (int d = 0; d < NW; d++) w[d] = tank[a * ND + d];
    return w;
  endfunction

  int last_lat = 0;

  // One request; at_pos >= 0 aligns the accept cycle to that pulse position.
  task automatic do_req(input logic wr, input int addr, input logic [NW-1:0] wd,
                        input int at_pos, input string tag);
    int lat, exp_lat, acc_pos, wait_s, bnd;
    logic [NW-1:0] exp_d;
    @(negedge r2_clk);
    bnd = 0;
    if (at_pos >= 0)
      while (pos != at_pos && bnd < NP + 4) begin @(negedge r2_clk); bnd++; end
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = 5'(addr); req_wdata = wd;
    acc_pos = pos;
    exp_d = wr ? wd : mem[addr];
    if (wr) mem[addr] = wd;
    wait_s = (addr * ND - acc_pos + NP) % NP;
    if (wait_s == 0) wait_s = NP;
    exp_lat = wait_s + ND;
    @(negedge r2_clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 700) begin @(negedge r2_clk); lat++; end
    last_lat = lat;
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_data"}, 32'(rsp_rdata), 32'(exp_d));
    chk({tag, "_busy"}, 32'(req_ready), 32'd0);
    @(negedge r2_clk);
    chk({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_hold"}, 32'(rsp_rdata), 32'(exp_d));
  endtask

  int b2b_addr [8];
  logic [NW-1:0] expq [$];
  int n_rsp = 0, busy_bad = 0;

  initial begin
    int bnd, seen, a;
    logic w;
    logic [NW-1:0] d;

    for (int i = 0; i < NM; i++) begin
      mem[i] = NW'($urandom);
      if (i == 0) mem[i] = 17'h10000;
      for (int k = 0; k < ND; k++)
        tank[i * ND + k] = (k < NW) ? mem[i][k] : 1'($urandom);
    end

    #1 r2_rst = 1'b1;
    repeat (3) @(negedge r2_clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_gates", 32'({clr, tin, tout, mib}), 32'd0);
    chk("rst_counter", 32'({minor, digit}), 32'd0);
    chk("rst_major_sync", 32'(major_sync), 32'd0);
    r2_rst = 1'b0;

    // Write then read slot 5; gates cover exactly (5,0..16).
    gate_cnt = 0;
    do_req(1'b1, 5, 17'h1ABCD, -1, "wr5");
    chk("wr5_gate_cnt", 32'(gate_cnt), 32'd17);
    chk("wr5_gate_first", 32'(gate_first), 32'(5 * ND));
    chk("wr5_gate_last", 32'(gate_last), 32'(5 * ND + 16));
    chk("wr5_gate_gap", 32'(gate_bad), 32'd0);
    chk("wr5_tank", 32'(tank_word(5)), 32'h1ABCD);
    chk("wr5_tank4", 32'(tank_word(4)), 32'(mem[4]));
    chk("wr5_tank6", 32'(tank_word(6)), 32'(mem[6]));
    gate_cnt = 0;
    do_req(1'b0, 5, '0, -1, "rd5");
    chk("rd5_gate_cnt", 32'(gate_cnt), 32'd17);
    chk("rd5_gate_first", 32'(gate_first), 32'(5 * ND));

    // Slot-miss boundary.
    do_req(1'b0, 7, '0, 7 * ND, "miss");
    chk("miss_594", 32'(last_lat), 32'd594);
    do_req(1'b0, 7, '0, 6 * ND + 17, "hit");
    chk("hit_19", 32'(last_lat), 32'd19);

    // Wrap around slot 31 -> 0.
    do_req(1'b1, 31, 17'h00001, -1, "wr31");
    do_req(1'b0, 0, '0, -1, "rd0");
    do_req(1'b0, 31, '0, -1, "rd31");

    // Back-to-back reads with req_valid held high.
    for (int i = 0; i < 8; i++) b2b_addr[i] = $urandom_range(0, NM - 1);
    @(negedge r2_clk);
    fork
      begin : b2b_drv
        int dbnd;
        req_valid = 1'b1;
        req_write = 1'b0;
        for (int i = 0; i < 8; i++) begin
          req_addr = 5'(b2b_addr[i]);
          dbnd = 0;
          while (!req_ready && dbnd < 700) begin @(negedge r2_clk); dbnd++; end
          expq.push_back(mem[b2b_addr[i]]);
          @(negedge r2_clk);
        end
        req_valid = 1'b0;
      end
      begin : b2b_mon
        int cyc;
        logic busy;
        logic [NW-1:0] e;
        cyc = 0;
        busy = 1'b0;
        while (n_rsp < 8 && cyc < 8 * 700) begin
          @(negedge r2_clk);
          #1;
          cyc++;
          if (busy && req_ready) busy_bad++;
          if (rsp_valid) begin
            n_rsp++;
            busy = 1'b0;
            chk("b2b_expected", 32'(expq.size() > 0), 32'd1);
            if (expq.size() > 0) begin
              e = expq.pop_front();
              chk("b2b_data", 32'(rsp_rdata), 32'(e));
            end
            chk("b2b_ready_done", 32'(req_ready), 32'd0);
          end
          if (req_valid && req_ready) busy = 1'b1;
        end
      end
    join
    chk("b2b_count", 32'(n_rsp), 32'd8);
    chk("b2b_leftover", 32'(expq.size()), 32'd0);
    chk("b2b_busy_ready", 32'(busy_bad), 32'd0);

    // Randomised traffic against the word-level model.
    for (int k = 0; k < 12; k++) begin
      a = $urandom_range(0, NM - 1);
      w = 1'($urandom);
      d = NW'($urandom);
      repeat ($urandom_range(0, 40)) @(negedge r2_clk);
      do_req(w, a, d, -1, w ? "rnd_wr" : "rnd_rd");
      chk("rnd_minor", 32'(minor), 32'(pos / ND));
      chk("rnd_digit", 32'(digit), 32'(pos % ND));
    end

    chk("ms_pulses_seen", 32'(ms_pulses >= 2), 32'd1);
    chk("ms_alignment", 32'(ms_bad), 32'd0);

    // Reset in the middle of a write to slot 10.
    @(negedge r2_clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd10; req_wdata = 17'h0F0F3;
    @(negedge r2_clk);
    req_valid = 1'b0;
    bnd = 0;
    while (pos != 10 * ND + 8 && bnd < 700) begin @(negedge r2_clk); bnd++; end
    chk("rstx_gate_pre", 32'({clr, tin, tout}), 32'b110);
    #2 r2_rst = 1'b1;
    #1;
    chk("rstx_gates", 32'({clr, tin, tout, mib}), 32'd0);
    chk("rstx_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstx_ready", 32'(req_ready), 32'd1);
    chk("rstx_rdata", 32'(rsp_rdata), 32'd0);
    seen = 0;
    repeat (2) begin @(negedge r2_clk); if (rsp_valid) seen++; end
    r2_rst = 1'b0;
    #1;
    chk("rstx_counter", 32'({minor, digit}), 32'd0);
    repeat (60) begin @(negedge r2_clk); if (rsp_valid) seen++; end
    chk("rstx_no_rsp", 32'(seen), 32'd0);
    for (int i = 0; i < NM; i++) mem[i] = tank_word(i);
    do_req(1'b0, 3, '0, -1, "rstx_rd3");

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
